// File: rtl/tv80_regbank.sv
// tv80_regbank: banked TV80 register file with EXX / EX DE,HL remapping,
// optional write bypass and a post-reset clearing sequencer.
module tv80_regbank #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int BANKS  = 2,
  parameter int SWAP_N = 3,
  parameter int BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cen,
  input  logic [AW-1:0]            addr_a,
  input  logic [AW-1:0]            addr_b,
  input  logic [AW-1:0]            addr_c,
  input  logic [DW-1:0]            di_h,
  input  logic [DW-1:0]            di_l,
  input  logic                     we_h,
  input  logic                     we_l,
  input  logic                     exx,
  input  logic                     ex_de_hl,
  output logic [DW-1:0]            do_ah,
  output logic [DW-1:0]            do_al,
  output logic [DW-1:0]            do_bh,
  output logic [DW-1:0]            do_bl,
  output logic [DW-1:0]            do_ch,
  output logic [DW-1:0]            do_cl,
  output logic [$clog2(BANKS)-1:0] bank,
  output logic                     busy
);
  localparam int ROWS = BANKS * SWAP_N + 2 ** AW - SWAP_N;
  localparam int PW   = $clog2(ROWS);
  localparam int BW   = $clog2(BANKS);

  logic [DW-1:0]    mem_h [ROWS];
  logic [DW-1:0]    mem_l [ROWS];
  logic [BANKS-1:0] flag;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    wp;
  logic [AW-1:0]    ra [3];
  logic [DW-1:0]    rh [3];
  logic [DW-1:0]    rl [3];
  logic             wr;

  // Banked entries live at b*SWAP_N; the swap flag exchanges DE (1) and HL (2).
  function automatic logic [PW-1:0] phys(input logic [AW-1:0] i, input logic [BW-1:0] b,
                                         input logic f);
    int j;
    j = int'(i);
    if (j < SWAP_N)
      return PW'(int'(b) * SWAP_N + ((f && j == 1) ? 2 : (f && j == 2) ? 1 : j));
    return PW'(BANKS * SWAP_N + j - SWAP_N);
  endfunction

  assign wr = cen && !busy;
  assign wp = phys(addr_a, bank, flag[bank]);
  assign ra = '{addr_a, addr_b, addr_c};

  for (genvar g = 0; g < 3; g++) begin : g_rd
    logic [PW-1:0] p;
    logic          hit;
    assign p     = phys(ra[g], bank, flag[bank]);
    assign hit   = BYPASS != 0 && wr && p == wp;
    assign rh[g] = busy ? '0 : (hit && we_h) ? di_h : mem_h[p];
    assign rl[g] = busy ? '0 : (hit && we_l) ? di_l : mem_l[p];
  end

  assign do_ah = rh[0];
  assign do_al = rl[0];
  assign do_bh = rh[1];
  assign do_bl = rl[1];
  assign do_ch = rh[2];
  assign do_cl = rl[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b1;
      ptr  <= '0;
      bank <= '0;
      flag <= '0;
    end else if (busy) begin
      ptr  <= ptr + 1'b1;
      busy <= ptr != PW'(ROWS - 1);
    end else if (cen) begin
      flag[bank] <= flag[bank] ^ ex_de_hl;
      if (exx) bank <= (bank == BW'(BANKS - 1)) ? '0 : bank + 1'b1;
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it one row per edge.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_h[ptr] <= '0;
      mem_l[ptr] <= '0;
    end else begin
      if (wr && we_h) mem_h[wp] <= di_h;
      if (wr && we_l) mem_l[wp] <= di_l;
    end
  end
endmodule

// File: tb/tb_tv80_regbank.sv
// tb_tv80_regbank: directed bench comparing a non-bypass and a bypass instance
// against a logical-register model every cycle, plus hand-computed spot values.
module tb_tv80_regbank;
  localparam int ROWS = 11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cen, we_h, we_l, exx, ex_de_hl;
  logic [2:0] addr_a, addr_b, addr_c;
  logic [7:0] di_h, di_l;
  logic [7:0] q0 [6];
  logic [7:0] q1 [6];
  logic [0:0] bank0, bank1;
  logic       busy0, busy1;

  tv80_regbank #(.BYPASS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cen(cen), .addr_a(addr_a), .addr_b(addr_b),
    .addr_c(addr_c), .di_h(di_h), .di_l(di_l), .we_h(we_h), .we_l(we_l), .exx(exx),
    .ex_de_hl(ex_de_hl), .do_ah(q0[0]), .do_al(q0[1]), .do_bh(q0[2]), .do_bl(q0[3]),
    .do_ch(q0[4]), .do_cl(q0[5]), .bank(bank0), .busy(busy0));

  tv80_regbank #(.BYPASS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cen(cen), .addr_a(addr_a), .addr_b(addr_b),
    .addr_c(addr_c), .di_h(di_h), .di_l(di_l), .we_h(we_h), .we_l(we_l), .exx(exx),
    .ex_de_hl(ex_de_hl), .do_ah(q1[0]), .do_al(q1[1]), .do_bh(q1[2]), .do_bl(q1[3]),
    .do_ch(q1[4]), .do_cl(q1[5]), .bank(bank1), .busy(busy1));

  always #5 clk = ~clk;

  // Model: per-bank logical registers (indexed after DE/HL swap) plus shared ones.
  logic [15:0] mb [2][3];
  logic [15:0] ms [5];
  logic [1:0]  mflag;
  logic        mbank;
  int          clr;

  function automatic int slot(input int x);
    return (mflag[mbank] && (x == 1 || x == 2)) ? 3 - x : x;
  endfunction

  function automatic logic [15:0] get(input int x);
    return x < 3 ? mb[mbank][slot(x)] : ms[x - 3];
  endfunction

  function automatic logic [15:0] merged(input logic [15:0] v);
    return {we_h ? di_h : v[15:8], we_l ? di_l : v[7:0]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr   <= ROWS;
      mbank <= 1'b0;
      mflag <= 2'b00;
      mb    <= '{default: '{default: 16'h0}};
      ms    <= '{default: 16'h0};
    end else if (clr > 0) begin
      clr <= clr - 1;
    end else if (cen) begin
      if (addr_a < 3) mb[mbank][slot(int'(addr_a))] <= merged(get(int'(addr_a)));
      else ms[int'(addr_a) - 3] <= merged(get(int'(addr_a)));
      mflag[mbank] <= mflag[mbank] ^ ex_de_hl;
      mbank <= mbank ^ exx;
    end
  end

  function automatic logic [15:0] expq(input logic [2:0] x, input bit byp);
    logic [15:0] v;
    v = clr > 0 ? 16'h0 : get(int'(x));
    if (byp && clr == 0 && cen && x == addr_a) v = merged(v);
    return v;
  endfunction

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 0;
  bit          lit_en = 0;
  logic [15:0] lit_b0, lit_b1;
  logic        lit_bank, lit_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    if (chk_on) begin
      logic [2:0] ad [3];
      ad = '{addr_a, addr_b, addr_c};
      chk("busy0", 32'(busy0), 32'(clr > 0));
      chk("busy1", 32'(busy1), 32'(clr > 0));
      chk("bank0", 32'(bank0), 32'(mbank));
      chk("bank1", 32'(bank1), 32'(mbank));
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("port%0d_nobyp", k), 32'({q0[2*k], q0[2*k+1]}), 32'(expq(ad[k], 0)));
        chk($sformatf("port%0d_byp", k), 32'({q1[2*k], q1[2*k+1]}), 32'(expq(ad[k], 1)));
      end
      if (lit_en) begin
        chk("lit_busy", 32'(busy0), 32'(lit_busy));
        chk("lit_bank", 32'(bank0), 32'(lit_bank));
        chk("lit_b_nobyp", 32'({q0[2], q0[3]}), 32'(lit_b0));
        chk("lit_b_byp", 32'({q1[2], q1[3]}), 32'(lit_b1));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    lit_en = 0;
  endtask

  task automatic lit(input logic [15:0] b0, input logic [15:0] b1, input logic bk,
                     input logic bs);
    lit_b0 = b0;
    lit_b1 = b1;
    lit_bank = bk;
    lit_busy = bs;
    lit_en = 1;
  endtask

  task automatic drv(input logic c, input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] d, input logic wh, input logic wl,
                     input logic x, input logic e);
    cen = c;
    addr_a = a;
    addr_b = b;
    addr_c = ~a;
    {di_h, di_l} = d;
    we_h = wh;
    we_l = wl;
    exx = x;
    ex_de_hl = e;
    tick();
  endtask

  task automatic idle(input logic [2:0] b);
    drv(1, b, b, 16'h0, 0, 0, 0, 0);
  endtask

  initial begin
    cen = 0; we_h = 0; we_l = 0; exx = 0; ex_de_hl = 0;
    addr_a = 0; addr_b = 0; addr_c = 0; di_h = 0; di_l = 0;
    #1 reset_n = 0;
    chk_on = 1;
    tick(); tick();
    reset_n = 1;
    repeat (10) tick();
    lit(16'h0, 16'h0, 0, 1); tick();
    lit(16'h0, 16'h0, 0, 0); tick();
    // bank rotation
    drv(1, 0, 0, 16'h1234, 1, 1, 0, 0);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    drv(1, 0, 0, 16'h5678, 1, 1, 0, 0);
    lit(16'h5678, 16'h5678, 1, 0); idle(0);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    lit(16'h1234, 16'h1234, 0, 0); idle(0);
    drv(1, 3, 3, 16'hABCD, 1, 1, 0, 0);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    lit(16'hABCD, 16'hABCD, 1, 0); idle(3);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    // EX DE,HL
    drv(1, 1, 1, 16'h1111, 1, 1, 0, 0);
    drv(1, 2, 2, 16'h2222, 1, 1, 0, 0);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 1);
    lit(16'h2222, 16'h2222, 0, 0); idle(1);
    lit(16'h1111, 16'h1111, 0, 0); idle(2);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    drv(1, 1, 1, 16'h3333, 1, 1, 0, 0);
    lit(16'h3333, 16'h3333, 1, 0); idle(1);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    lit(16'h2222, 16'h2222, 0, 0); idle(1);
    // simultaneous write + ex_de_hl + exx from an unswapped bank 0
    drv(1, 0, 0, 16'h0, 0, 0, 0, 1);
    lit(16'h1111, 16'h1111, 0, 0); idle(1);
    drv(1, 1, 1, 16'h5A5A, 1, 1, 1, 1);
    lit(16'h3333, 16'h3333, 1, 0); idle(1);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    lit(16'h5A5A, 16'h5A5A, 0, 0); idle(2);
    lit(16'h2222, 16'h2222, 0, 0); idle(1);
    // low-half-only write: bypass instance forwards, the other shows old data
    lit(16'hABCD, 16'hABA5, 0, 0); drv(1, 3, 3, 16'hFFA5, 0, 1, 0, 0);
    lit(16'hABA5, 16'hABA5, 0, 0); idle(3);
    // cen low blocks writes and exchanges
    drv(0, 4, 4, 16'h7777, 1, 1, 1, 1);
    lit(16'h0, 16'h0, 0, 0); idle(4);
    // reset in mid-operation, then writes during the clear are dropped
    drv(1, 5, 5, 16'h9999, 1, 1, 0, 0);
    lit(16'h9999, 16'h9999, 0, 0); idle(5);
    drv(1, 0, 0, 16'h0, 0, 0, 1, 0);
    reset_n = 0;
    lit(16'h0, 16'h0, 0, 1); drv(1, 0, 0, 16'hEEEE, 1, 1, 1, 1);
    drv(1, 0, 0, 16'hEEEE, 1, 1, 1, 1);
    reset_n = 1;
    repeat (10) drv(1, 0, 0, 16'hEEEE, 1, 1, 1, 1);
    lit(16'h0, 16'h0, 0, 1); drv(1, 0, 0, 16'hEEEE, 1, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      lit(16'h0, 16'h0, 0, 0);
      idle(3'(i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tv80_regbank.md
# tv80_regbank

Parametrised, banked general-purpose register file for the TV80 core family. It replaces the flat 8-entry H/L register pair with a banked array that supports Z80-style `EXX` bank rotation and `EX DE,HL` remapping in hardware, optional same-cycle write bypass, and a post-reset clearing sequencer. It sits between the TV80 datapath (three read ports A/B/C, one write port on A) and the core's instruction decoder, which issues the exchange strobes.

## Interface
Parameters:
- `DW`, 8: width of each half (H and L) of an entry.
- `AW`, 3: logical address width; logical depth is 2^AW.
- `BANKS`, 2: number of banks for the banked entries; must be ≥ 2.
- `SWAP_N`, 3: logical entries 0..SWAP_N-1 are banked; the rest are shared. Must be ≥ 3 and ≤ 2^AW.
- `BYPASS`, 0: when 1, enables combinational write-to-read forwarding.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cen` in 1: clock enable for writes and exchange strobes.
- `addr_a` in AW: read port A address; also the write address.
- `addr_b` in AW: read port B address.
- `addr_c` in AW: read port C address.
- `di_h` in DW: write data, high half.
- `di_l` in DW: write data, low half.
- `we_h` in 1: write enable, high half.
- `we_l` in 1: write enable, low half.
- `exx` in 1: advance the current bank.
- `ex_de_hl` in 1: toggle the DE/HL swap flag of the current bank.
- `do_ah`, `do_al` out DW: port A read data.
- `do_bh`, `do_bl` out DW: port B read data.
- `do_ch`, `do_cl` out DW: port C read data.
- `bank` out clog2(BANKS): current bank index.
- `busy` out 1: clearing sequencer active.

## Operation
- Physical rows: `ROWS = BANKS*SWAP_N + 2^AW - SWAP_N` (default 11). Each row has separate H and L halves.
- Logical-to-physical mapping for index i, bank b, swap flag f[b]:
  - i < SWAP_N: if f[b] is set, exchange i=1 with i=2; then phys = b*SWAP_N + i'.
  - i ≥ SWAP_N: phys = BANKS*SWAP_N + (i - SWAP_N).
- All three read ports and the write port use the same mapping.
- Reads are combinational from storage.
- Write: on a rising edge with `cen` set and `busy` clear, write `di_h` into H if `we_h` is set, and `di_l` into L if `we_l` is set, at phys(`addr_a`).
- `exx` (with `cen` set and `busy` clear): `bank <= (bank+1) mod BANKS`. Swap flags are per bank and persist across rotations.
- `ex_de_hl` (with `cen` set and `busy` clear): toggles f[bank].
- Strobes asserted together in one cycle:
  - A write uses the pre-edge mapping.
  - `ex_de_hl` toggles the flag of the pre-edge bank.
  - `exx` then advances the bank.
- `BYPASS=1`: if a write is active this cycle and a read port's phys equals the write phys, that port returns `di_*` for each enabled half, in the same cycle. Non-enabled halves read storage. With `BYPASS=0`, reads return the old value until after the edge.
- Clearing sequencer:
  - Reset assertion forces `busy=1`, row pointer = 0, `bank=0`, all f=0.
  - After reset release, each rising edge zeroes both halves of one row, regardless of `cen`.
  - The pointer increments; after row ROWS-1 is cleared, `busy` drops.
- While `busy` is set:
  - All read outputs are forced to 0.
  - Writes, `exx` and `ex_de_hl` are ignored and not queued.
- Reset asserted mid-operation aborts everything and restarts the clear from row 0.

## Timing
- Reset values: all `do_*` = 0, `bank` = 0, `busy` = 1.
- Clear duration: ROWS rising edges after `reset_n` deasserts (11 at defaults). `busy` is low and storage is usable starting at cycle ROWS+1.
- Write-to-read latency:
  - `BYPASS=0`: 1 cycle; data is visible after the write edge.
  - `BYPASS=1`: 0 cycles.
- Exchange latency: the new mapping applies to reads after the strobe edge.
- `cen` low: no writes and no exchanges take effect; reads still track addresses.

## Test plan
- Reset release with `cen=0`: `busy` stays 1 for 11 edges, then 0; all reads return 0; `bank=0`.
- Bank rotation:
  - Write 0x12/0x34 to logical 0 in bank 0; pulse `exx`; write 0x56/0x78 to logical 0; read back 0x5678.
  - Pulse `exx` again (`bank=0`); read back 0x1234.
  - Write logical 3, rotate, read logical 3: same value.
- EX DE,HL:
  - Write DE=0x1111, HL=0x2222; pulse `ex_de_hl`; port B reading logical 1 returns 0x2222 and logical 2 returns 0x1111.
  - `exx` to bank 1 shows bank 1 unswapped; `exx` back to bank 0 shows it still swapped.
- Simultaneous strobes: a write to logical 1 plus `exx` plus `ex_de_hl` in one cycle writes bank 0 phys 1, sets f[0], and leaves `bank=1`.
- Bypass:
  - `BYPASS=1`, `we_l` only, `di_l=0xA5`, `addr_b=addr_a`: `do_bl=0xA5` in the same cycle; `do_bh` shows the old value.
  - `BYPASS=0`: `do_bl` shows the old value until the edge.
- Mid-operation reset:
  - Assert `reset_n=0` after writes; on release, writes during `busy` are dropped.
  - After 11 edges all entries read 0 and `bank=0`.
